bch_dec_ctrl: RTL and testbench
===============================

Name: bch_dec_ctrl

Overview:
- Top-level sequencer for the hard-decision BCH decode path.
- Accepts one codeword job per handshake and latches the code configuration (n, t, m).
- Runs, in order: syndrome calculation, zero-syndrome check, Berlekamp-Massey, then Chien search.
- Reports a per-codeword status and error count on an output valid/ready handshake.

Parameters:
- T_MAX, 4: maximum correction capability; sets the syndrome bus width.
- M_MAX, 10: maximum field degree; bits per syndrome.
- TIMEOUT, 2047: maximum cycles to wait for any stage's done before aborting.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  job request.
- in_ready  out  1  controller can accept a job.
- n  in  10  code length.
- t  in  4  correction capability.
- m  in  4  field degree.
- n_r  out  10  latched n, driven to datapath.
- t_r  out  4  latched t.
- m_r  out  4  latched m.
- syn_start  out  1  one-cycle start pulse to syndrome block.
- syn_done  in  1  syndrome block finished.
- syndromes  in  2*T_MAX*M_MAX  packed S1..S2T_MAX, S1 in the LSBs.
- bm_start  out  1  one-cycle start pulse to Berlekamp-Massey.
- bm_done  in  1  BM finished.
- bm_fail  in  1  BM locator degree exceeds t; valid with bm_done.
- bm_deg  in  4  locator degree; valid with bm_done.
- chien_start  out  1  one-cycle start pulse to Chien search.
- chien_done  in  1  Chien search finished.
- chien_root_cnt  in  4  roots found; valid with chien_done.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_status  out  2  00 clean; 01 corrected; 10 uncorrectable; 11 config or timeout error.
- out_err_cnt  out  4  number of corrected errors; 0 unless status = 01.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State = IDLE. Latched config and watchdog counter cleared.
- States: IDLE, SYN, CHK, BM, CHIEN, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch n, t, m into n_r, t_r, m_r.
  - Config is valid only when m is in 3..M_MAX, n = 2^m - 1, and t is in 1..T_MAX.
  - Valid config -> SYN, and syn_start pulses high for exactly the next cycle.
  - Invalid config -> OUT with status 11 and err_cnt 0; no start pulses are issued.
- SYN: wait for syn_done, then go to CHK.
- CHK (exactly one cycle):
  - Examine only S1..S(2*t_r), and only the low m_r bits of each.
  - All of those zero -> OUT with status 00.
  - Otherwise -> BM, with bm_start pulsing for one cycle.
- BM:
  - On bm_done with bm_fail = 1 -> OUT with status 10.
  - On bm_done with bm_fail = 0: latch bm_deg -> CHIEN, with chien_start pulsing for one cycle.
- CHIEN: on chien_done:
  - chien_root_cnt equal to latched bm_deg -> status 01, out_err_cnt = bm_deg.
  - Otherwise -> status 10.
  - Both cases -> OUT.
- OUT:
  - out_valid held high, with status and count stable, until out_ready is sampled high.
  - Then go to IDLE, with out_valid deasserted on the following cycle.
- Job-to-job: in_ready is 0 from job accept until the cycle after the output handshake. There is no overlap of jobs.
- Start pulses are registered outputs, high for exactly one cycle per stage entry.
- Watchdog:
  - Cleared on entry to SYN, BM and CHIEN; increments each cycle in those states.
  - On reaching TIMEOUT without the expected done -> OUT with status 11 and err_cnt 0.
  - A done arriving in the same cycle the count reaches TIMEOUT wins: normal transition.
- Stray done: a done input that does not match the current state is ignored, including any done seen in IDLE or OUT.
- Fastest path: accept cycle C; syn_start at C+1; zero check at the cycle after syn_done; out_valid one cycle after that.
- Reset asserted mid-job: immediate return to IDLE and reset values. Any partially issued pulse is dropped.

Test Plan:
- Clean codeword: n=1023, m=10, t=4; syn_done returns all-zero syndromes -> exactly one syn_start, no bm_start; out_status=00, out_err_cnt=0.
- Correctable: n=63, m=6, t=3; S1=0x15; bm_done with bm_deg=2, fail=0; chien_root_cnt=2 -> out_status=01, out_err_cnt=2.
- Masking: m=6, t=2; only S5 nonzero, and only bit 8 set in S1 -> treated as clean, status 00.
- Uncorrectable:
  - bm_fail=1 -> status 10 and no chien_start.
  - bm_deg=3 with chien_root_cnt=1 -> status 10.
- Config and timeout:
  - n=100, m=7 -> status 11 with no start pulses.
  - syn_done withheld for 2047 cycles -> status 11.
- Backpressure and reset: out_ready held low 20 cycles -> out_valid and status stable, in_ready stays 0. Separately, rstn pulsed low during BM -> state returns to IDLE, in_ready=1, busy=0.

Source files
------------

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl -- top-level sequencer for the hard-decision BCH decode path.
//
// Accepts one codeword job, latches its code configuration (n, t, m) and steps
// the datapath through syndrome calculation, a zero-syndrome check,
// Berlekamp-Massey and Chien search. It then reports a status and an error count.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload until that edge, and the
// consumer may raise or lower ready freely. in_valid/in_ready carry the job
// (n, t, m). out_valid/out_ready carry the result (out_status, out_err_cnt).
// out_valid and the result stay stable until the transfer.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready, n,t,m   job request and its code configuration
//   n_r, t_r, m_r              latched configuration for the datapath
//   syn_start/syn_done         syndrome stage; syndromes = S1..S2T_MAX, S1 in LSBs
//   bm_start/bm_done           Berlekamp-Massey; bm_fail, bm_deg valid with done
//   chien_start/chien_done     Chien search; chien_root_cnt valid with done
//   out_valid/out_ready        result handshake
//   out_status                 00 clean, 01 corrected, 10 uncorrectable,
//                              11 config error or stage timeout
//   out_err_cnt                corrected error count (0 unless status 01)
//   busy                       high whenever the sequencer is not idle
//   state_dbg                  current FSM state, for observation
module bch_dec_ctrl #(
  parameter int T_MAX   = 4,
  parameter int M_MAX   = 10,
  parameter int TIMEOUT = 2047
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9:0]               n,
  input  logic [3:0]               t,
  input  logic [3:0]               m,
  output logic [9:0]               n_r,
  output logic [3:0]               t_r,
  output logic [3:0]               m_r,
  output logic                     syn_start,
  input  logic                     syn_done,
  input  logic [2*T_MAX*M_MAX-1:0] syndromes,
  output logic                     bm_start,
  input  logic                     bm_done,
  input  logic                     bm_fail,
  input  logic [3:0]               bm_deg,
  output logic                     chien_start,
  input  logic                     chien_done,
  input  logic [3:0]               chien_root_cnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_status,
  output logic [3:0]               out_err_cnt,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYN   = 3'd1,
    CHK   = 3'd2,
    BM    = 3'd3,
    CHIEN = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd;
  logic [3:0]     deg_r;
  logic [15:0]    pow_m;
  logic           cfg_ok;
  logic           wd_expired;
  logic [M_MAX-1:0] bit_mask;
  logic           syn_nz;

  // in_ready and busy are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // A job is decodable only for a supported field and a full-length code.
  assign pow_m  = 16'd1 << m;
  assign cfg_ok = (m >= 4'd3) && (int'(m) <= M_MAX) &&
                  ({6'd0, n} == (pow_m - 16'd1)) &&
                  (t != 4'd0) && (int'(t) <= T_MAX);

  // The watchdog holds at TIMEOUT for one cycle. A done in that cycle still
  // takes the normal transition, and only a missing done aborts the job.
  assign wd_expired = (wd == WDW'(TIMEOUT));

  // Zero check: only S1..S(2*t_r) matter, and only their low m_r bits. The
  // syndrome block keeps its outputs steady after syn_done.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < M_MAX; b++) begin
      bit_mask[b] = (b < int'(m_r));
    end
    syn_nz = 1'b0;
    for (int i = 0; i < 2 * T_MAX; i++) begin
      if (i < 2 * int'(t_r)) begin
        syn_nz = syn_nz | (|(syndromes[i*M_MAX +: M_MAX] & bit_mask));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wd          <= '0;
      deg_r       <= '0;
      n_r         <= '0;
      t_r         <= '0;
      m_r         <= '0;
      syn_start   <= 1'b0;
      bm_start    <= 1'b0;
      chien_start <= 1'b0;
      out_valid   <= 1'b0;
      out_status  <= 2'b00;
      out_err_cnt <= '0;
    end else begin
      // Start strobes are high only for the cycle after a stage is entered.
      syn_start   <= 1'b0;
      bm_start    <= 1'b0;
      chien_start <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            n_r <= n;
            t_r <= t;
            m_r <= m;
            if (cfg_ok) begin
              state     <= SYN;
              syn_start <= 1'b1;
              wd        <= '0;
            end else begin
              state       <= OUT;
              out_valid   <= 1'b1;
              out_status  <= 2'b11;
              out_err_cnt <= '0;
            end
          end
        end

        SYN: begin
          if (syn_done) begin
            state <= CHK;
          end else if (wd_expired) begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_status  <= 2'b11;
            out_err_cnt <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        CHK: begin
          if (syn_nz) begin
            state    <= BM;
            bm_start <= 1'b1;
            wd       <= '0;
          end else begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_status  <= 2'b00;
            out_err_cnt <= '0;
          end
        end

        BM: begin
          if (bm_done) begin
            if (bm_fail) begin
              state       <= OUT;
              out_valid   <= 1'b1;
              out_status  <= 2'b10;
              out_err_cnt <= '0;
            end else begin
              deg_r       <= bm_deg;
              state       <= CHIEN;
              chien_start <= 1'b1;
              wd          <= '0;
            end
          end else if (wd_expired) begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_status  <= 2'b11;
            out_err_cnt <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        CHIEN: begin
          if (chien_done) begin
            state     <= OUT;
            out_valid <= 1'b1;
            // A locator whose degree differs from its root count is not
            // a valid error pattern.
            if (chien_root_cnt == deg_r) begin
              out_status  <= 2'b01;
              out_err_cnt <= deg_r;
            end else begin
              out_status  <= 2'b10;
              out_err_cnt <= '0;
            end
          end else if (wd_expired) begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_status  <= 2'b11;
            out_err_cnt <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        OUT: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_status  <= 2'b00;
            out_err_cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Directed bench for bch_dec_ctrl. A table of jobs, each with its datapath
// responses and expected result, is run through a behavioural datapath
// responder. Hand-written sequences cover the timing and corner cases:
// fastest path, watchdog boundary, backpressure, stray dones and mid-job reset.
module tb_bch_dec_ctrl;

  localparam int T_MAX   = 4;
  localparam int M_MAX   = 10;
  localparam int TIMEOUT = 2047;
  localparam int SW      = 2 * T_MAX * M_MAX;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready;
  logic [9:0]    n, n_r;
  logic [3:0]    t, t_r, m, m_r;
  logic          syn_start, syn_done;
  logic [SW-1:0] syndromes;
  logic          bm_start, bm_done, bm_fail;
  logic [3:0]    bm_deg;
  logic          chien_start, chien_done;
  logic [3:0]    chien_root_cnt;
  logic          out_valid, out_ready;
  logic [1:0]    out_status;
  logic [3:0]    out_err_cnt;
  logic          busy;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  bch_dec_ctrl #(.T_MAX(T_MAX), .M_MAX(M_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .t(t), .m(m),
    .n_r(n_r), .t_r(t_r), .m_r(m_r),
    .syn_start(syn_start), .syn_done(syn_done), .syndromes(syndromes),
    .bm_start(bm_start), .bm_done(bm_done), .bm_fail(bm_fail), .bm_deg(bm_deg),
    .chien_start(chien_start), .chien_done(chien_done),
    .chien_root_cnt(chien_root_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_status(out_status), .out_err_cnt(out_err_cnt),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [9:0]    n;
    logic [3:0]    t;
    logic [3:0]    m;
    logic [SW-1:0] syn;
    logic          bm_fail;
    logic [3:0]    bm_deg;
    logic [3:0]    roots;
    logic [1:0]    st;
    logic [3:0]    err;
    int            nsyn;
    int            nbm;
    int            nch;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] s_at(input int k, input logic [9:0] v);
    logic [SW-1:0] r;
    r = '0;
    r[(k-1)*M_MAX +: M_MAX] = v;
    return r;
  endfunction

  function automatic vec_t mk(input logic [9:0] vn, input logic [3:0] vt,
                              input logic [3:0] vm, input logic [SW-1:0] vs,
                              input logic vf, input logic [3:0] vd,
                              input logic [3:0] vr, input logic [1:0] vst,
                              input logic [3:0] ve, input int a, input int b,
                              input int c);
    vec_t v;
    v.n = vn; v.t = vt; v.m = vm; v.syn = vs;
    v.bm_fail = vf; v.bm_deg = vd; v.roots = vr;
    v.st = vst; v.err = ve; v.nsyn = a; v.nbm = b; v.nch = c;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end at 1 time unit after a rising edge.
  task automatic accept(input int idx);
    vec_t v;
    v = vecs[idx];
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    syndromes = v.syn;
    n = v.n; t = v.t; m = v.m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cfg_latched", {14'd0, n_r, t_r, m_r}, {14'd0, v.n, v.t, v.m});
    chk("syn_start_next_cycle", 32'(syn_start), 32'(v.nsyn));
  endtask

  // Behavioural datapath: each stage answers two cycles after its start.
  task automatic respond(input int idx, input bit pre_syn);
    vec_t v;
    int sd, bd, cd, cs, cb, cc;
    bit seen;
    logic [5:0] e;
    v = vecs[idx];
    exp_q.push_back({v.st, v.err});
    sd = -1; bd = -1; cd = -1; cs = 0; cb = 0; cc = 0; seen = 1'b0;
    if (pre_syn) begin cs = 1; sd = 1; end
    for (int c = 0; c < 300; c++) begin
      syn_done = 1'b0; bm_done = 1'b0; chien_done = 1'b0;
      bm_fail = 1'b0; bm_deg = 4'd0; chien_root_cnt = 4'd0;
      if (out_valid) begin seen = 1'b1; break; end
      if (syn_start)   begin cs++; sd = 2; end
      if (bm_start)    begin cb++; bd = 2; end
      if (chien_start) begin cc++; cd = 2; end
      if (sd > 0) begin sd--; if (sd == 0) syn_done = 1'b1; end
      if (bd > 0) begin
        bd--;
        if (bd == 0) begin bm_done = 1'b1; bm_fail = v.bm_fail; bm_deg = v.bm_deg; end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin chien_done = 1'b1; chien_root_cnt = v.roots; end
      end
      @(posedge clk); #1;
    end
    chk("out_valid_within_bound", 32'(seen), 32'd1);
    e = exp_q.pop_front();
    chk("out_status", 32'(out_status), 32'(e[5:4]));
    chk("out_err_cnt", 32'(out_err_cnt), 32'(e[3:0]));
    chk("syn_start_count", 32'(cs), 32'(v.nsyn));
    chk("bm_start_count", 32'(cb), 32'(v.nbm));
    chk("chien_start_count", 32'(cc), 32'(v.nch));
    chk("in_ready_while_out", 32'(in_ready), 32'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    chk("busy_after_handshake", 32'(busy), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    // Jobs: n, t, m, syndromes, bm_fail, bm_deg, roots, status, err, #syn, #bm, #chien
    vecs[0]  = mk(10'd1023, 4'd4, 4'd10, '0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1, 0, 0);
    vecs[1]  = mk(10'd63, 4'd3, 4'd6, s_at(1, 10'h015), 1'b0, 4'd2, 4'd2, 2'b01, 4'd2, 1, 1, 1);
    vecs[2]  = mk(10'd63, 4'd2, 4'd6, s_at(5, 10'h03f) | s_at(1, 10'h100),
                  1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1, 0, 0);
    vecs[3]  = mk(10'd31, 4'd2, 4'd5, s_at(2, 10'h001), 1'b1, 4'd3, 4'd0, 2'b10, 4'd0, 1, 1, 0);
    vecs[4]  = mk(10'd127, 4'd4, 4'd7, s_at(8, 10'h001), 1'b0, 4'd3, 4'd1, 2'b10, 4'd0, 1, 1, 1);
    vecs[5]  = mk(10'd100, 4'd2, 4'd7, s_at(1, 10'h001), 1'b0, 4'd0, 4'd0, 2'b11, 4'd0, 0, 0, 0);
    vecs[6]  = mk(10'd7, 4'd0, 4'd3, s_at(1, 10'h001), 1'b0, 4'd0, 4'd0, 2'b11, 4'd0, 0, 0, 0);
    vecs[7]  = mk(10'd15, 4'd5, 4'd4, s_at(1, 10'h001), 1'b0, 4'd0, 4'd0, 2'b11, 4'd0, 0, 0, 0);
    vecs[8]  = mk(10'd3, 4'd1, 4'd2, s_at(1, 10'h001), 1'b0, 4'd0, 4'd0, 2'b11, 4'd0, 0, 0, 0);
    vecs[9]  = mk(10'd7, 4'd1, 4'd3, s_at(2, 10'h004), 1'b0, 4'd1, 4'd1, 2'b01, 4'd1, 1, 1, 1);
    vecs[10] = mk(10'd7, 4'd1, 4'd3, s_at(3, 10'h3ff) | s_at(1, 10'h008),
                  1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1, 0, 0);
    vecs[11] = mk(10'd1023, 4'd4, 4'd10, s_at(1, 10'h200), 1'b0, 4'd4, 4'd4, 2'b01, 4'd4, 1, 1, 1);

    rstn = 1'b0; in_valid = 1'b0; n = '0; t = '0; m = '0;
    syn_done = 1'b0; syndromes = '0; bm_done = 1'b0; bm_fail = 1'b0; bm_deg = '0;
    chien_done = 1'b0; chien_root_cnt = '0; out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs_zero",
        {12'd0, out_valid, busy, syn_start, bm_start, chien_start, out_status, out_err_cnt, state_dbg},
        32'd0);
    chk("rst_cfg_zero", {14'd0, n_r, t_r, m_r}, 32'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven jobs
    for (int i = 0; i < NV; i++) begin
      accept(i);
      respond(i, 1'b0);
      drain();
    end

    // Stray dones in IDLE are ignored
    syn_done = 1'b1; bm_done = 1'b1; chien_done = 1'b1;
    @(posedge clk); #1;
    syn_done = 1'b0; bm_done = 1'b0; chien_done = 1'b0;
    chk("stray_idle", {27'd0, busy, in_ready, out_valid, syn_start, bm_start}, 32'h8);

    // Fastest path: syn_done in the syn_start cycle, out_valid two cycles later
    accept(0);
    syn_done = 1'b1;
    @(posedge clk); #1;
    syn_done = 1'b0;
    chk("fast_chk_state", 32'(state_dbg), 32'd2);
    chk("fast_no_out_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("fast_out_valid", 32'(out_valid), 32'd1);
    chk("fast_status", 32'(out_status), 32'd0);
    drain();

    // Stray bm_done/chien_done during SYN are ignored
    accept(1);
    bm_done = 1'b1; bm_fail = 1'b1; chien_done = 1'b1; chien_root_cnt = 4'd7;
    @(posedge clk); #1;
    bm_done = 1'b0; bm_fail = 1'b0; chien_done = 1'b0; chien_root_cnt = 4'd0;
    chk("stray_syn_state", 32'(state_dbg), 32'd1);
    chk("stray_syn_no_out", 32'(out_valid), 32'd0);
    respond(1, 1'b1);

    // Backpressure: result stays stable while out_ready is low
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("backpressure_hold", {25'd0, out_valid, in_ready, out_status, out_err_cnt},
          {25'd0, 1'b1, 1'b0, 2'b01, 4'd2});
    end
    drain();

    // Watchdog: syn_done never arrives
    accept(0);
    for (int c = 0; c < TIMEOUT; c++) begin @(posedge clk); #1; end
    chk("timeout_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("timeout_out_valid", 32'(out_valid), 32'd1);
    chk("timeout_status", {26'd0, out_status, out_err_cnt}, {26'd0, 2'b11, 4'd0});
    drain();

    // Watchdog boundary: a done in the expiry cycle still wins
    accept(0);
    for (int c = 0; c < TIMEOUT; c++) begin @(posedge clk); #1; end
    syn_done = 1'b1;
    @(posedge clk); #1;
    syn_done = 1'b0;
    chk("boundary_done_wins", 32'(state_dbg), 32'd2);
    @(posedge clk); #1;
    chk("boundary_status", {25'd0, out_valid, out_status, out_err_cnt}, {25'd0, 1'b1, 2'b00, 4'd0});
    drain();

    // Reset asserted during BM, just as bm_start is issued
    accept(1);
    syn_done = 1'b1;
    @(posedge clk); #1;
    syn_done = 1'b0;
    @(posedge clk); #1;
    chk("bm_start_before_reset", 32'(bm_start), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midreset_idle", 32'(state_dbg), 32'd0);
    chk("midreset_flags", {28'd0, in_ready, busy, bm_start, out_valid}, 32'h8);
    chk("midreset_cfg", {14'd0, n_r, t_r, m_r}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    accept(0);
    respond(0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
